// File: rtl/run_length_meter.sv
// run_length_meter: measures space or mark run length after a rising edge
// on b, reporting a saturating count with an overflow flag on a vld strobe.
module run_length_meter #(
    parameter int CNT_W   = 3,
    parameter int MIN_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic             mode,
    output logic [CNT_W-1:0] len,
    output logic             vld,
    output logic             sat,
    output logic             busy,
    output logic [1:0]       st
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MARK  = 2'b01,
        SPACE = 2'b10
    } st_e;

    localparam logic [CNT_W-1:0] MAX_C = '1;
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    st_e              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             vld_q, vld_d;
    logic             sat_q, sat_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;
    logic             run_end;
    logic             long_enough;

    // Saturating increment of the run counter and sticky overflow.
    always_comb begin
        cnt_inc     = (cnt_q == MAX_C) ? MAX_C : cnt_q + ONE_C;
        ovf_inc     = ovf_q | (cnt_q == MAX_C);
        long_enough = (cnt_q >= MIN_C);
    end

    // Next-state, counter and report decode; a mode change overrides all.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mode_d  = mode;
        run_end = 1'b0;
        if (mode != mode_q) begin
            st_d  = IDLE;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (!mode_q) begin
            unique case (st_q)
                IDLE: begin
                    if (b) begin
                        st_d = MARK;
                    end
                end
                MARK: begin
                    if (!b) begin
                        st_d  = SPACE;
                        cnt_d = ONE_C;
                        ovf_d = 1'b0;
                    end
                end
                SPACE: begin
                    if (b) begin
                        run_end = 1'b1;
                        st_d    = MARK;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                        ovf_d = ovf_inc;
                    end
                end
                default: begin
                    st_d  = IDLE;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end else begin
            unique case (st_q)
                IDLE, SPACE: begin
                    if (b) begin
                        st_d  = MARK;
                        cnt_d = ONE_C;
                        ovf_d = 1'b0;
                    end
                end
                MARK: begin
                    if (!b) begin
                        run_end = 1'b1;
                        st_d    = SPACE;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                        ovf_d = ovf_inc;
                    end
                end
                default: begin
                    st_d  = IDLE;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            endcase
        end
    end

    // Report outputs are zero unless a qualifying run just ended.
    always_comb begin
        vld_d = run_end & long_enough;
        len_d = vld_d ? cnt_q : '0;
        sat_d = vld_d & ovf_q;
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            mode_q <= mode;
            len_q  <= '0;
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            mode_q <= mode_d;
            len_q  <= len_d;
            vld_q  <= vld_d;
            sat_q  <= sat_d;
        end
    end

    // busy is a combinational decode of the state register.
    always_comb begin
        len  = len_q;
        vld  = vld_q;
        sat  = sat_q;
        st   = st_q;
        busy = (st_q != IDLE);
    end

endmodule

// File: tb/tb_run_length_meter.sv
// tb_run_length_meter: directed vectors for run_length_meter, one instance
// with MIN_LEN=1 and one with MIN_LEN=2 sharing the same stimulus.
module tb_run_length_meter;

    logic       clk;
    logic       rst;
    logic       b;
    logic       mode;
    logic [2:0] len0, len1;
    logic       vld0, vld1;
    logic       sat0, sat1;
    logic       busy0, busy1;
    logic [1:0] st0, st1;

    int checks;
    int failures;

    run_length_meter #(.CNT_W(3), .MIN_LEN(1)) u0 (
        .clk  (clk),
        .rst  (rst),
        .b    (b),
        .mode (mode),
        .len  (len0),
        .vld  (vld0),
        .sat  (sat0),
        .busy (busy0),
        .st   (st0)
    );

    run_length_meter #(.CNT_W(3), .MIN_LEN(2)) u1 (
        .clk  (clk),
        .rst  (rst),
        .b    (b),
        .mode (mode),
        .len  (len1),
        .vld  (vld1),
        .sat  (sat1),
        .busy (busy1),
        .st   (st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // apply b, let one rising edge pass, settle 1 time unit after it
    task automatic step(input logic bv);
        b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic out0(input string tag, input logic v, input logic [2:0] l,
                        input logic s, input logic [1:0] stx);
        chk({tag, "_vld"}, 32'(vld0), 32'(v));
        chk({tag, "_len"}, 32'(len0), 32'(l));
        chk({tag, "_sat"}, 32'(sat0), 32'(s));
        chk({tag, "_st"}, 32'(st0), 32'(stx));
        chk({tag, "_busy"}, 32'(busy0), 32'(stx != 2'b00));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        mode = 1'b0;
        b    = 1'b0;
        @(negedge clk);

        // reset held with b toggling
        step(1'b1);
        out0("rst_a", 1'b0, 3'd0, 1'b0, 2'b00);
        step(1'b0);
        out0("rst_b", 1'b0, 3'd0, 1'b0, 2'b00);
        rst = 1'b0;

        // reset mid-space drops the run
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        chk("rst_mid_st", 32'(st0), 32'(2'b10));
        rst = 1'b1;
        step(1'b1);
        out0("rst_mid", 1'b0, 3'd0, 1'b0, 2'b00);
        rst = 1'b0;
        step(1'b0);
        chk("rst_mid_after_vld", 32'(vld0), 32'(1'b0));

        // basic space: 1,0,0,1
        step(1'b1);
        chk("basic_st1", 32'(st0), 32'(2'b01));
        step(1'b0);
        chk("basic_sp_vld", 32'(vld0), 32'(1'b0));
        step(1'b0);
        step(1'b1);
        out0("basic", 1'b1, 3'd2, 1'b0, 2'b01);
        step(1'b1);
        out0("basic_off", 1'b0, 3'd0, 1'b0, 2'b01);

        // saturation: nine zeros
        for (int i = 0; i < 9; i++) step(1'b0);
        out0("sat9_run", 1'b0, 3'd0, 1'b0, 2'b10);
        step(1'b1);
        out0("sat9", 1'b1, 3'd7, 1'b1, 2'b01);

        // exactly seven zeros: full but not overflowed
        for (int i = 0; i < 7; i++) step(1'b0);
        step(1'b1);
        out0("sat7", 1'b1, 3'd7, 1'b0, 2'b01);
        step(1'b1);
        chk("sat7_off", 32'(vld0), 32'(1'b0));

        // back-to-back: 1,0,1,0,0,0,1
        step(1'b1);
        step(1'b0);
        step(1'b1);
        out0("b2b_1", 1'b1, 3'd1, 1'b0, 2'b01);
        step(1'b0);
        chk("b2b_gap_a", 32'(vld0), 32'(1'b0));
        step(1'b0);
        chk("b2b_gap_b", 32'(vld0), 32'(1'b0));
        step(1'b0);
        chk("b2b_gap_c", 32'(vld0), 32'(1'b0));
        step(1'b1);
        out0("b2b_2", 1'b1, 3'd3, 1'b0, 2'b01);

        // mode change to mark mode forces IDLE
        mode = 1'b1;
        step(1'b0);
        out0("mchg", 1'b0, 3'd0, 1'b0, 2'b00);

        // mark mode: 0,1,1,1,0,1,0
        step(1'b0);
        chk("mark_idle", 32'(st0), 32'(2'b00));
        step(1'b1);
        chk("mark_st", 32'(st0), 32'(2'b01));
        step(1'b1);
        step(1'b1);
        step(1'b0);
        out0("mark_3", 1'b1, 3'd3, 1'b0, 2'b10);
        step(1'b1);
        out0("mark_gap", 1'b0, 3'd0, 1'b0, 2'b01);
        step(1'b0);
        out0("mark_1", 1'b1, 3'd1, 1'b0, 2'b10);

        // toggle mode mid-mark: the ending sample must not report
        step(1'b1);
        step(1'b1);
        mode = 1'b0;
        step(1'b0);
        out0("mark_abort", 1'b0, 3'd0, 1'b0, 2'b00);
        step(1'b0);
        chk("mark_abort_after", 32'(vld0), 32'(1'b0));

        // glitch filter on MIN_LEN=2 instance: 1,0,1,0,0,1
        step(1'b1);
        chk("glt_st", 32'(st1), 32'(2'b01));
        step(1'b0);
        step(1'b1);
        chk("glt_drop_vld", 32'(vld1), 32'(1'b0));
        chk("glt_drop_len", 32'(len1), 32'(3'd0));
        chk("glt_ref_vld", 32'(vld0), 32'(1'b1));
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("glt_vld", 32'(vld1), 32'(1'b1));
        chk("glt_len", 32'(len1), 32'(3'd2));
        chk("glt_sat", 32'(sat1), 32'(1'b0));
        chk("glt_busy", 32'(busy1), 32'(1'b1));
        step(1'b1);
        chk("glt_off", 32'(vld1), 32'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_length_meter.md
# run_length_meter

Parametrised run-length meter for a single serial input `b`. After a rising edge on `b` it measures the length, in clock cycles, of the following idle (0) run, or of the active (1) run, selected by `mode`. Each completed run produces a one-cycle `vld` strobe with a saturating count and an overflow flag. It sits next to the existing gap decoders and improves on them in five ways:

- parametrised count width
- mark-length mode
- glitch filter
- explicit overflow flag
- back-to-back measurement with no lost runs

## Interface
- `CNT_W`, default 3: width of `len`. Saturation value `MAX = 2**CNT_W-1`. Legal range 2..16.
- `MIN_LEN`, default 1: runs shorter than `MIN_LEN` cycles are discarded with no `vld`. Legal range 1..`MAX`.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `b`  in  1  serial input, sampled each rising edge.
- `mode`  in  1  0 = measure space (0-run after a mark); 1 = measure mark (1-run).
- `len`  out  CNT_W  measured length, `min(run, MAX)`. Holds 0 when `vld`=0.
- `vld`  out  1  one-cycle report strobe.
- `sat`  out  1  qualified by `vld`: 1 iff the true run length was greater than `MAX`. 0 when `vld`=0.
- `busy`  out  1  1 when `st` != IDLE.
- `st`  out  2  state, for debug: IDLE=00, MARK=01, SPACE=10. 11 is unused.

## Operation
- **Registers:**
  - `st`
  - run counter `cnt` (CNT_W bits, saturates at `MAX`)
  - overflow bit `ovf`, set when an increment is attempted with `cnt`==`MAX`
  - `mode_q` (registered `mode`)
  - output registers `len`, `vld`, `sat`
- **Counter rule:** entering a run loads `cnt`=1 and `ovf`=0. Each further sample of the same level increments `cnt` with saturation. `cnt` never wraps.
- **Report rule:** a measured run ends when `b` takes the opposite level.
  - If `cnt` >= `MIN_LEN`: next cycle `vld`=1, `len`=`cnt`, `sat`=`ovf`.
  - Otherwise nothing is reported.
- **Mode 0 (space) transitions:**
  - IDLE: b=1 -> MARK. b=0 -> stay.
  - MARK: b=1 -> stay. b=0 -> SPACE with `cnt`=1.
  - SPACE: b=0 -> stay and count. b=1 -> report, then MARK.
  - A report never passes through IDLE, so a space that starts on the cycle after a report is measured.
- **Mode 1 (mark) transitions:**
  - IDLE: b=1 -> MARK with `cnt`=1. b=0 -> stay.
  - MARK: b=1 -> stay and count. b=0 -> report, then SPACE.
  - SPACE: b=1 -> MARK with `cnt`=1. b=0 -> stay.
- **Spaces before the first mark** after reset or a mode change are never measured.
- **Mode change:** when `mode` != `mode_q` at an edge, the next state is IDLE, `cnt` and `ovf` clear, and no report is made even if a run was in progress. `mode_q` updates on the same edge.
- **Runs to saturation:** a space or mark longer than `MAX` keeps `cnt`=`MAX` and stays in its state indefinitely. There is no timeout.

## Timing
- **Reset:** `rst`=1 at an edge gives, after that edge, `st`=IDLE, `cnt`=0, `ovf`=0, `len`=0, `vld`=0, `sat`=0, `busy`=0 and `mode_q`=`mode`. This holds mid-run too: any pending run is dropped and no `vld` is produced. `rst` has priority over every other condition.
- **Report latency:** if the terminating sample of `b` is taken at edge k, then `vld`/`len`/`sat` are valid from edge k to edge k+1 and return to 0 at edge k+1, unless another report is due.
- **Report rate:** consecutive reports are at least 2 cycles apart, since a run is at least 1 cycle long.
- **Combinational outputs:** `busy` decodes `st` combinationally. All other outputs are registered.
- **No handshake:** the consumer must capture `len` on the `vld` cycle.

## Test plan
Scenarios 1–5 use `CNT_W`=3 and `MIN_LEN`=1. Scenario 6 uses `MIN_LEN`=2.

1. **Reset:** `rst`=1 for 2 cycles with b toggling -> `st`=00, `len`=0, `vld`=0, `sat`=0, `busy`=0 throughout. Repeat with `rst` asserted in SPACE after 3 zeros -> no `vld`, `st`=00 after the edge.
2. **Basic space:** mode=0, b = 1,0,0,1 on successive edges -> single `vld` in the cycle after the final 1, `len`=2, `sat`=0, `st`=01 afterwards.
3. **Saturation:** mode=0, b = 1, then nine 0s, then 1 -> `len`=7, `sat`=1. Repeat with exactly seven 0s -> `len`=7, `sat`=0.
4. **Back-to-back:** mode=0, b = 1,0,1,0,0,0,1 -> two `vld` pulses, `len`=1 then `len`=3, with `vld` low between them.
5. **Mark mode:** mode=1, b = 0,1,1,1,0,1,0 -> `len`=3, then `len`=1. Also toggle `mode` mid-mark -> no `vld`, `st`=00 next cycle.
6. **Glitch filter:** `MIN_LEN`=2, mode=0, b = 1,0,1,0,0,1 -> the first space is dropped; a single `vld` with `len`=2.
